// File: rtl/sw_cmd_pkg.sv
// Shared switch indexing and command priority for the vacuum-cleaner input stage.
package sw_cmd_pkg;

  localparam int N_SW_DEF = 4;

  // Bit positions of the slide switches within SW.
  typedef enum logic [1:0] {
    PWR_OFF = 2'd0,
    ON      = 2'd1,
    CLEAN   = 2'd2,
    EVADE   = 2'd3
  } sw_idx_e;

  // Highest priority first.
  localparam sw_idx_e PRIO_ORDER [N_SW_DEF] = '{PWR_OFF, EVADE, CLEAN, ON};

  // Pick the highest-priority asserted switch; all zero when none is asserted.
  function automatic logic [N_SW_DEF-1:0] resolve_prio(input logic [N_SW_DEF-1:0] lvl);
    logic [N_SW_DEF-1:0] res;
    logic                found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N_SW_DEF; i++) begin
      if (!found && lvl[PRIO_ORDER[i]]) begin
        res[PRIO_ORDER[i]] = 1'b1;
        found              = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sw_cmd_conditioner_if.sv
// Switch bundle: raw levels in, conditioned levels/pulses/command out.
interface sw_cmd_conditioner_if #(
  parameter int N_SW = 4
);

  logic [N_SW-1:0] SW;
  logic [N_SW-1:0] sw_level;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] cmd_onehot;
  logic            cmd_valid;
  logic [7:0]      glitch_cnt;

  // Board/bench side: drives raw switches, observes conditioned outputs.
  modport master (
    output SW,
    input  sw_level,
    input  sw_rise,
    input  cmd_onehot,
    input  cmd_valid,
    input  glitch_cnt
  );

  // Conditioner side.
  modport slave (
    input  SW,
    output sw_level,
    output sw_rise,
    output cmd_onehot,
    output cmd_valid,
    output glitch_cnt
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-flop synchroniser, debounce counter, stable level and rise pulse.
// abort flags a cycle where a partial count is thrown away by the input returning.
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic abort
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Debounce next-state: count while the input differs, accept on the last count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    abort   = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
      abort = (cnt_q != '0);
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync_meta <= sw_raw;
      sync_q    <= sync_meta;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sw_cmd_conditioner.sv
// Switch conditioner: per-bit debounce lanes plus registered priority command.
// Optional rejected-bounce counter enabled by defining SW_GLITCH_CNT_EN.
module sw_cmd_conditioner
  import sw_cmd_pkg::*;
#(
  parameter int N_SW            = N_SW_DEF,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 CPU_RESETN,
  sw_cmd_conditioner_if.slave  bus
);

  logic [N_SW-1:0] level;
  logic [N_SW-1:0] rise;
  logic [N_SW-1:0] abort;
  logic [N_SW-1:0] cmd_onehot_q;
  logic            cmd_valid_q;

  for (genvar i = 0; i < N_SW; i++) begin : g_lane
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .sw_raw (bus.SW[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .abort  (abort[i])
    );
  end

  // Command lags the debounced levels by one cycle so it never sees a half-updated set.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      cmd_onehot_q <= '0;
      cmd_valid_q  <= 1'b0;
    end else begin
      cmd_onehot_q <= resolve_prio(level);
      cmd_valid_q  <= |level;
    end
  end

`ifdef SW_GLITCH_CNT_EN
  logic [7:0] glitch_q;

  // One increment per cycle with any aborted bounce, saturating at 255.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      glitch_q <= 8'd0;
    end else if ((|abort) && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign bus.glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort   = ^abort;
  assign bus.glitch_cnt = 8'd0;
`endif

  assign bus.sw_level   = level;
  assign bus.sw_rise    = rise;
  assign bus.cmd_onehot = cmd_onehot_q;
  assign bus.cmd_valid  = cmd_valid_q;

endmodule

// File: doc/sw_cmd_conditioner.md
Name: sw_cmd_conditioner

Overview:
- Upstream input stage for the vacuum-cleaner Moore FSM.
- Takes the four raw slide switches (power_off, on, cleaning, evading) and synchronises each to CLK100MHZ, debounces it, and produces clean levels, one-cycle rise pulses and a priority-resolved one-hot command.
- The top level wires its outputs into the FSM's power_off/on/cleaning/evading inputs in place of raw SW bits.

Parameters:
- N_SW, 4, number of switch inputs. The bit order is fixed: 0=power_off, 1=on, 2=cleaning, 3=evading.
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles an input must differ from its stable value before it is accepted (10 ms at 100 MHz). Legal range is 2..2^24-1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter. This is derived and must not be overridden.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESETN  input  1  synchronous active-low reset.
- SW  input  N_SW  raw asynchronous switch levels.
- sw_level  output  N_SW  debounced switch levels.
- sw_rise  output  N_SW  one-cycle pulse when a debounced bit goes 0->1.
- cmd_onehot  output  N_SW  highest-priority asserted debounced switch, one-hot. All zero if no switch is asserted.
- cmd_valid  output  1  OR of sw_level.
- glitch_cnt  output  8  rejected-bounce counter (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock domain, CLK100MHZ.
  - Reset is synchronous and active-low: CPU_RESETN sampled low on a rising edge resets every register.
- Reset values:
  - sync stages, counters, sw_level, sw_rise, cmd_onehot: 0.
  - cmd_valid: 0.
  - glitch_cnt: 0.
- Synchroniser: a 2-flop chain per bit; sync_q is the second flop.
- Per-bit debounce, evaluated every cycle:
  - sync_q == sw_level[i]: counter <= 0.
  - sync_q != sw_level[i] and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync_q != sw_level[i] and counter == DEBOUNCE_CYCLES-1: sw_level[i] <= sync_q and counter <= 0.
  - Any return of sync_q to sw_level[i] before acceptance clears the counter. A fully restarted count is then required.
- Latency:
  - A clean SW edge before rising edge k appears on sw_level at edge k+1+DEBOUNCE_CYCLES.
  - That is 2 synchroniser edges plus DEBOUNCE_CYCLES-1 counting edges, with the acceptance edge inclusive.
- sw_rise:
  - Registered; high for exactly the one cycle following the edge on which sw_level[i] went 0->1.
  - Falls produce no pulse.
- Command resolution:
  - Priority is power_off > evading > cleaning > on.
  - cmd_onehot is registered from sw_level, so it lags sw_level by one cycle.
  - It is always one-hot or zero.
- cmd_valid is registered in the same cycle as cmd_onehot.
- Boundary conditions:
  - Simultaneous switch changes are debounced independently. Bits accepted on the same edge update together, and priority resolves on the next cycle.
  - Counter saturation cannot occur, because the counter never exceeds DEBOUNCE_CYCLES-1.
  - Reset mid-count discards the partial count. After reset release, the current SW values are debounced again from a stable value of 0.
  - A switch held high through reset therefore re-accepts DEBOUNCE_CYCLES+2 cycles after release and produces a sw_rise pulse.

Optional Feature:
- Macro: SW_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt increments once per cycle in which any bit's counter is cleared by sync_q returning to sw_level with counter != 0 (an aborted bounce).
  - If several bits abort in the same cycle, the increment is still 1.
  - It saturates at 255 and is cleared only by reset.
- Undefined: glitch_cnt is tied to 8'd0 and no counter logic is synthesised. The port list is identical in both builds.

Decomposition:
- Package sw_cmd_pkg holds:
  - the sw_idx_e enum (PWR_OFF=0, ON=1, CLEAN=2, EVADE=3);
  - localparam N_SW_DEF=4;
  - the priority order as a constant array of sw_idx_e.
- The FSM top level imports the package for switch indexing.
- Sub-module sw_debounce_bit (one synchroniser plus counter plus stable flop plus rise pulse) is generated N_SW times. Priority and glitch logic live in the parent.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=8.
- Reset: hold CPU_RESETN=0 for 3 cycles with SW=4'b1111 -> all outputs 0 during reset. Release -> sw_level=4'b1111 exactly 10 edges later, sw_rise=4'b1111 for 1 cycle, next cycle cmd_onehot=4'b0001 and cmd_valid=1.
- Clean edge: SW[1] 0->1 -> sw_level[1]=1 at edge +10 and sw_rise[1]=1 for one cycle. cmd_onehot=4'b0010 from edge +11.
- Bounce: SW[2] toggles 1,0 every 3 cycles for 30 cycles, then holds 1 -> sw_level[2] stays 0 until 10 edges after the final rise. With SW_GLITCH_CNT_EN, glitch_cnt=5.
- Priority: debounced SW=4'b0110, then SW[3] raised -> cmd_onehot goes 4'b0100 to 4'b1000. Then SW[0] raised -> cmd_onehot=4'b0001. Then all cleared -> cmd_onehot=0 and cmd_valid=0.
- Fall: SW[1] 1->0 -> sw_level[1]=0 at edge +10 with no sw_rise pulse.
- Reset mid-count: SW[3] raised, CPU_RESETN pulsed low at count 5 -> sw_level[3] stays 0, then accepted 10 edges after reset release.
